rtc_lectura_ciclica: RTL and testbench

- Executes the controller's "while true" phase: continuously reads the RTC time registers over the multiplexed address/data bus.
- Started by the main controller's whileT level. Reads 6 consecutive RTC registers and publishes a coherent time snapshot.
- Pulses finwt for one cycle so the controller can move on to its user-request check.

---
 rtl/rtc_lectura_ciclica.sv | 181 ++++++++++++++++++
 tb/tb_rtc_lectura_ciclica.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_lectura_ciclica.sv
// Cyclic RTC time reader: walks N_REG consecutive registers over the multiplexed
// A/D bus and publishes them as one coherent BCD snapshot, pulsing finwt when done.
module rtc_lectura_ciclica #(
    parameter int unsigned T_PHASE   = 10,
    parameter logic [7:0]  ADDR_BASE = 8'h21,
    parameter int unsigned N_REG     = 6
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       whileT,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       a_d,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       finwt,
    output logic       ocupado,
    output logic [7:0] seg,
    output logic [7:0] min,
    output logic [7:0] hora,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] anio
);

    localparam int unsigned CW = (T_PHASE < 1) ? 1 : $clog2(T_PHASE + 1);
    localparam int unsigned IW = 3;
    localparam int unsigned NS = 6;
    localparam logic [CW-1:0] RELOAD = CW'(T_PHASE - 1);

    typedef enum logic [3:0] {
        IDLE, A_SET, A_WR, A_HOLD, D_SET, D_RD, D_HOLD, DONE, WAIT_LOW
    } state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [CW-1:0] cnt;
    logic          phase_end;
    logic [7:0]    shadow [NS];

    logic [7:0] ad_out_nxt;
    logic       ad_oe_nxt, a_d_nxt, cs_n_nxt, rd_n_nxt, wr_n_nxt, finwt_nxt, ocupado_nxt;

    assign phase_end = (cnt == '0);

    // State register; the phase counter reloads on every state change
    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= RELOAD;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (state_nxt != state) begin
                cnt <= RELOAD;
            end else if (!phase_end) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // Next state; dropping whileT mid-sequence aborts straight back to IDLE
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                idx_nxt = '0;
                if (whileT) state_nxt = A_SET;
            end
            A_SET, A_WR, A_HOLD, D_SET, D_RD, D_HOLD: begin
                if (!whileT) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else if (phase_end) begin
                    case (state)
                        A_SET:  state_nxt = A_WR;
                        A_WR:   state_nxt = A_HOLD;
                        A_HOLD: state_nxt = D_SET;
                        D_SET:  state_nxt = D_RD;
                        D_RD:   state_nxt = D_HOLD;
                        D_HOLD: begin
                            if (idx < IW'(N_REG - 1)) begin
                                state_nxt = A_SET;
                                idx_nxt   = idx + IW'(1);
                            end else begin
                                state_nxt = DONE;
                            end
                        end
                        default: state_nxt = IDLE;
                    endcase
                end
            end
            DONE:     state_nxt = WAIT_LOW;
            WAIT_LOW: if (!whileT) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Bus values for the state being entered; registered below so they align with it
    always_comb begin
        ad_out_nxt  = '0;
        ad_oe_nxt   = 1'b0;
        a_d_nxt     = a_d;
        cs_n_nxt    = 1'b1;
        rd_n_nxt    = 1'b1;
        wr_n_nxt    = 1'b1;
        finwt_nxt   = 1'b0;
        ocupado_nxt = 1'b0;
        case (state_nxt)
            A_SET, A_WR, A_HOLD: begin
                a_d_nxt     = 1'b0;
                ad_oe_nxt   = 1'b1;
                ad_out_nxt  = ADDR_BASE + 8'(idx_nxt);
                ocupado_nxt = 1'b1;
                if (state_nxt == A_WR) begin
                    cs_n_nxt = 1'b0;
                    wr_n_nxt = 1'b0;
                end
            end
            D_SET, D_RD, D_HOLD: begin
                a_d_nxt     = 1'b1;
                ocupado_nxt = 1'b1;
                if (state_nxt == D_RD) begin
                    cs_n_nxt = 1'b0;
                    rd_n_nxt = 1'b0;
                end
            end
            DONE: begin
                finwt_nxt   = 1'b1;
                ocupado_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // Output registers, shadow capture and snapshot publish
    always_ff @(posedge CLK) begin
        if (reset) begin
            ad_out  <= '0;
            ad_oe   <= 1'b0;
            a_d     <= 1'b0;
            cs_n    <= 1'b1;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
            finwt   <= 1'b0;
            ocupado <= 1'b0;
            seg     <= '0;
            min     <= '0;
            hora    <= '0;
            dia     <= '0;
            mes     <= '0;
            anio    <= '0;
            for (int i = 0; i < NS; i++) shadow[i] <= '0;
        end else begin
            ad_out  <= ad_out_nxt;
            ad_oe   <= ad_oe_nxt;
            a_d     <= a_d_nxt;
            cs_n    <= cs_n_nxt;
            rd_n    <= rd_n_nxt;
            wr_n    <= wr_n_nxt;
            finwt   <= finwt_nxt;
            ocupado <= ocupado_nxt;
            if (state == D_RD && phase_end && whileT) begin
                shadow[idx] <= ad_in;
            end
            if (state == D_HOLD && state_nxt == DONE) begin
                seg  <= shadow[0];
                min  <= shadow[1];
                hora <= shadow[2];
                dia  <= shadow[3];
                mes  <= shadow[4];
                anio <= shadow[5];
            end
        end
    end

endmodule

// File: tb/tb_rtc_lectura_ciclica.sv
// Randomized bench for rtc_lectura_ciclica: an RTC register-file model answers two
// readers (T_PHASE=10 and T_PHASE=1); snapshots, latency and bus timing are scored.
module tb_rtc_lectura_ciclica;

    localparam int unsigned TP0  = 10;
    localparam int unsigned TP1  = 1;
    localparam int unsigned LAT0 = 1 + 6 * 6 * TP0;
    localparam int unsigned LAT1 = 1 + 6 * 6 * TP1;

    logic CLK = 1'b0;
    logic reset = 1'b1;
    logic whileT = 1'b0;

    logic [7:0] ad_in0, ad_out0, seg0, min0, hora0, dia0, mes0, anio0;
    logic       ad_oe0, a_d0, cs_n0, rd_n0, wr_n0, finwt0, ocupado0;
    logic [7:0] ad_in1, ad_out1, seg1, min1, hora1, dia1, mes1, anio1;
    logic       ad_oe1, a_d1, cs_n1, rd_n1, wr_n1, finwt1, ocupado1;
    logic [47:0] snap0, snap1;

    assign snap0 = {seg0, min0, hora0, dia0, mes0, anio0};
    assign snap1 = {seg1, min1, hora1, dia1, mes1, anio1};

    rtc_lectura_ciclica #(.T_PHASE(TP0)) u0 (
        .CLK(CLK), .reset(reset), .whileT(whileT), .ad_in(ad_in0),
        .ad_out(ad_out0), .ad_oe(ad_oe0), .a_d(a_d0), .cs_n(cs_n0), .rd_n(rd_n0),
        .wr_n(wr_n0), .finwt(finwt0), .ocupado(ocupado0),
        .seg(seg0), .min(min0), .hora(hora0), .dia(dia0), .mes(mes0), .anio(anio0)
    );

    rtc_lectura_ciclica #(.T_PHASE(TP1)) u1 (
        .CLK(CLK), .reset(reset), .whileT(whileT), .ad_in(ad_in1),
        .ad_out(ad_out1), .ad_oe(ad_oe1), .a_d(a_d1), .cs_n(cs_n1), .rd_n(rd_n1),
        .wr_n(wr_n1), .finwt(finwt1), .ocupado(ocupado1),
        .seg(seg1), .min(min1), .hora(hora1), .dia(dia1), .mes(mes1), .anio(anio1)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;
    int edges = 0;
    int start_e = 0;
    int fin0 = 0;
    int fin1 = 0;
    bit rst_q = 1'b0;
    bit wt_q = 1'b0;
    bit armed = 1'b0;
    logic [7:0]  mem [256];
    logic [7:0]  lat0 = '0, lat1 = '0;
    logic [47:0] exp0 = '0, exp1 = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [47:0] mem_snap();
        return {mem[8'h21], mem[8'h22], mem[8'h23], mem[8'h24], mem[8'h25], mem[8'h26]};
    endfunction

    task automatic rand_mem();
        for (int i = 0; i < 6; i++) mem[8'(33 + i)] = 8'($urandom);
    endtask

    task automatic wait_fin0(input int budget);
        int n = 0;
        while (!finwt0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk("fin0_seen", 64'(finwt0), 64'd1);
    endtask

    // RTC model: latch the address on the write strobe, return its register on read
    always @(posedge CLK) begin
        edges++;
        rst_q = reset;
        wt_q  = whileT;
        if (reset) armed = 1'b1;
        if (!cs_n0 && !wr_n0) lat0 <= ad_out0;
        if (!cs_n1 && !wr_n1) lat1 <= ad_out1;
    end

    always_comb ad_in0 = rd_n0 ? 8'hEE : mem[lat0];
    always_comb ad_in1 = rd_n1 ? 8'hEE : mem[lat1];

    // Scoreboard for the T_PHASE=10 reader
    int  wr_run0 = 0, rd_run0 = 0, k0 = 0;
    bit  fin_prev0 = 1'b0;
    always @(negedge CLK) begin
        if (armed) begin
            if (rst_q) exp0 = '0;
            if (finwt0) begin
                fin0++;
                exp0 = mem_snap();
                chk("lat0", 64'(edges - start_e), 64'(LAT0));
                chk("fin_single0", 64'(fin_prev0), 64'd0);
            end
            fin_prev0 = finwt0;
            chk("snap0", 64'(snap0), 64'(exp0));
            if (!rd_n0) chk("rd_bus0", 64'({ad_oe0, cs_n0}), 64'd0);
            if (!wr_n0) chk("wr_cs0", 64'(cs_n0), 64'd0);
            if (!wr_n0) begin
                wr_run0++;
            end else if (wr_run0 > 0) begin
                if (wt_q && !rst_q) begin
                    chk("wr_len0", 64'(wr_run0), 64'(TP0));
                    chk("addr0", 64'(ad_out0), 64'(8'h21 + k0));
                    k0++;
                end
                wr_run0 = 0;
            end
            if (!rd_n0) begin
                rd_run0++;
            end else if (rd_run0 > 0) begin
                if (wt_q && !rst_q) chk("rd_len0", 64'(rd_run0), 64'(TP0));
                rd_run0 = 0;
            end
            if (!ocupado0) k0 = 0;
        end
    end

    // Scoreboard for the T_PHASE=1 reader
    always @(negedge CLK) begin
        if (armed) begin
            if (rst_q) exp1 = '0;
            if (finwt1) begin
                fin1++;
                exp1 = mem_snap();
                chk("lat1", 64'(edges - start_e), 64'(LAT1));
            end
            chk("snap1", 64'(snap1), 64'(exp1));
            if (!rd_n1) chk("rd_bus1", 64'({ad_oe1, cs_n1}), 64'd0);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] saved;
        int f, n;
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
        mem[8'h21] = 8'h45; mem[8'h22] = 8'h30; mem[8'h23] = 8'h12;
        mem[8'h24] = 8'h15; mem[8'h25] = 8'h09; mem[8'h26] = 8'h16;

        // Reset held with whileT high: bus must stay idle
        reset  = 1'b1;
        whileT = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk("rst_bus", 64'({cs_n0, rd_n0, wr_n0, ad_oe0, ocupado0, finwt0}), 64'b111000);
            chk("rst_out", 64'({ad_out0, a_d0}), 64'd0);
            chk("rst_snap", 64'(snap0), 64'd0);
        end
        reset   = 1'b0;
        start_e = edges;
        @(negedge CLK);
        chk("aset_ctl", 64'({ocupado0, ad_oe0, cs_n0, a_d0, wr_n0}), 64'b11101);
        chk("aset_addr", 64'(ad_out0), 64'h21);

        // Fixed full read
        wait_fin0(LAT0 + 20);
        chk("seg", 64'(seg0), 64'h45);
        chk("min", 64'(min0), 64'h30);
        chk("hora", 64'(hora0), 64'h12);
        chk("dia", 64'(dia0), 64'h15);
        chk("mes", 64'(mes0), 64'h09);
        chk("anio", 64'(anio0), 64'h16);
        chk("snap1_fixed", 64'(snap1), 64'h453012150916);

        // Re-arm guard: whileT stays high, nothing may restart
        repeat (5) begin
            @(negedge CLK);
            chk("rearm_idle", 64'({ocupado0, cs_n0, ad_oe0, finwt0}), 64'b0100);
        end
        whileT = 1'b0;
        @(negedge CLK);
        chk("rearm_low", 64'({ocupado0, cs_n0, ad_oe0}), 64'b010);
        rand_mem();
        whileT  = 1'b1;
        start_e = edges;
        @(negedge CLK);
        chk("rearm_start", 64'(ocupado0), 64'd1);
        wait_fin0(LAT0 + 20);

        // Random sequences with random low gaps and post-finwt holds
        for (int s = 0; s < 4; s++) begin
            whileT = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge CLK);
            rand_mem();
            whileT  = 1'b1;
            start_e = edges;
            wait_fin0(LAT0 + 20);
            repeat ($urandom_range(1, 6)) @(negedge CLK);
        end

        // Abort during the data read of the fourth register
        whileT = 1'b0;
        @(negedge CLK);
        rand_mem();
        saved   = snap0;
        whileT  = 1'b1;
        start_e = edges;
        n = 0;
        while (!(!rd_n0 && lat0 == 8'h24) && n < int'(LAT0)) begin
            @(negedge CLK);
            n++;
        end
        chk("abort_reach", 64'(!rd_n0 && lat0 == 8'h24), 64'd1);
        f = fin0;
        whileT = 1'b0;
        @(negedge CLK);
        chk("abort_bus", 64'({cs_n0, rd_n0, ocupado0}), 64'b110);
        chk("abort_snap", 64'(snap0), 64'(saved));
        repeat (LAT0) @(negedge CLK);
        chk("abort_nofin", 64'(fin0 - f), 64'd0);
        chk("abort_hold", 64'(snap0), 64'(saved));

        // Reset during an address write strobe
        whileT  = 1'b1;
        start_e = edges;
        n = 0;
        while (wr_n0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("rstmid_reach", 64'(wr_n0), 64'd0);
        f = fin0;
        reset = 1'b1;
        @(negedge CLK);
        chk("rstmid_bus", 64'({wr_n0, cs_n0, ocupado0, finwt0}), 64'b1100);
        chk("rstmid_snap", 64'(snap0), 64'd0);
        reset  = 1'b0;
        whileT = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rstmid_nofin", 64'(fin0 - f), 64'd0);

        // Recovery read after the reset
        rand_mem();
        whileT  = 1'b1;
        start_e = edges;
        wait_fin0(LAT0 + 20);
        whileT = 1'b0;
        repeat (3) @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
